// File: rtl/sipo_frame_ctrl.sv
// Frame controller for an external serial-in/parallel-out shift register:
// gates the shift enable for WIDTH qualified bits, then captures the
// assembled word and offers it on a valid/ready handshake.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             ser_in,
  output logic             shift_en,
  output logic             shift_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture_c;
  logic             drop_c;

  // Serial bit goes straight through; only the enable is qualified.
  assign shift_in = ser_in;
  assign busy     = (state_q != IDLE);

  // State and bit-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, bit counting, shift gating and LOAD capture/drop decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_en  = 1'b0;
    capture_c = 1'b0;
    drop_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        shift_en = bit_valid;
        if (bit_valid) begin
          if (cnt_q == LAST_BIT) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
        if (!data_valid || data_ready) begin
          capture_c = 1'b1;
        end else begin
          drop_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register, output handshake and single-cycle overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= drop_c;
      if (capture_c) begin
        data_out   <= par_in;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
